// File: rtl/mio_sw_input_pkg.sv
// Shared definitions for the MIO switch-input peripheral: register offsets, CTRL layout, bus base.
// Pure constants, no logic; no latency or backpressure of its own.
// Imported by the top module.
package mio_sw_input_pkg;

   typedef enum logic [1:0] {
      MIO_SW_STATE = 2'd0,
      MIO_SW_EVENT = 2'd1,
      MIO_SW_CTRL  = 2'd2,
      MIO_SW_RAW   = 2'd3
   } sw_reg_e;

   localparam int CTRL_IRQ_EN_BIT = 0;
   localparam int CTRL_MASK_LSB   = 16;
   localparam int MAX_NSW         = 16;

   // Base of this block in the MIO window; MIO_BUS decodes sel from it.
   localparam logic [31:0] MIO_SW_BASE_ADDR = 32'hE000_0010;

endpackage

// File: rtl/mio_sw_input_sw_debounce.sv
// One switch bit: 2-FF synchroniser, saturating stability counter, accepted level, change pulse.
// Latency: raw after 2 cycles, stable level after 2 + DEBOUNCE_CYCLES cycles.
// No backpressure; change is a single-cycle combinational pulse on the committing edge.
module sw_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic sw,
   output logic raw,
   output logic stable,
   output logic change
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic             sync_q;
   logic             raw_q;
   logic             stable_q;
   logic [CNT_W-1:0] cnt_q;

   // Fires on the edge that completes the stable window, so the parent can latch it together with the new level.
   assign change = (raw_q != stable_q) && (cnt_q == CNT_LAST);
   assign raw    = raw_q;
   assign stable = stable_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= 1'b0;
         raw_q    <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q <= sw;
         raw_q  <= sync_q;
         if (raw_q == stable_q) begin
            cnt_q <= '0;
         end else if (change) begin
            stable_q <= raw_q;
            cnt_q    <= '0;
         end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mio_sw_input.sv
// MIO switch-input peripheral: debounced STATE, W1C EVENT flags, CTRL irq enable/mask, RAW view.
// Reads are combinational (zero wait); irq is registered, one cycle behind EVENT/CTRL.
// No backpressure: writes are accepted every cycle sel & we is high.
module mio_sw_input
   import mio_sw_input_pkg::*;
#(
   parameter int NSW             = 16,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NSW-1:0] sw_i,
   input  logic           sel,
   input  logic           we,
   input  logic [1:0]     addr,
   input  logic [31:0]    wdata,
   output logic [31:0]    rdata,
   output logic           irq
);

   logic [NSW-1:0] raw;
   logic [NSW-1:0] state;
   logic [NSW-1:0] change;
   logic [NSW-1:0] evt_q;
   logic [NSW-1:0] irq_mask_q;
   logic [NSW-1:0] evt_clr;
   logic           irq_en_q;
   logic           irq_q;
   logic           wr_evt;
   logic           wr_ctrl;
   logic           unused_wdata;

   for (genvar i = 0; i < NSW; i++) begin : g_sw
      sw_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_deb (
         .clk    (clk),
         .rst    (rst),
         .sw     (sw_i[i]),
         .raw    (raw[i]),
         .stable (state[i]),
         .change (change[i])
      );
   end

   assign wr_evt  = sel && we && (addr == MIO_SW_EVENT);
   assign wr_ctrl = sel && we && (addr == MIO_SW_CTRL);
   assign evt_clr = wr_evt ? wdata[NSW-1:0] : '0;
   assign unused_wdata = ^wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_q      <= '0;
         irq_en_q   <= 1'b0;
         irq_mask_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         // OR-ing change after the clear lets a fresh event beat a same-cycle W1C.
         evt_q <= (evt_q & ~evt_clr) | change;
         if (wr_ctrl) begin
            irq_en_q   <= wdata[CTRL_IRQ_EN_BIT];
            irq_mask_q <= wdata[CTRL_MASK_LSB +: NSW];
         end
         irq_q <= irq_en_q & (|(evt_q & irq_mask_q));
      end
   end

   assign irq = irq_q;

   always_comb begin
      rdata = '0;
      case (addr)
         MIO_SW_STATE: rdata[NSW-1:0] = state;
         MIO_SW_EVENT: rdata[NSW-1:0] = evt_q;
         MIO_SW_CTRL: begin
            rdata[CTRL_MASK_LSB +: NSW] = irq_mask_q;
            rdata[CTRL_IRQ_EN_BIT]      = irq_en_q;
         end
         MIO_SW_RAW:   rdata[NSW-1:0] = raw;
         default:      rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_mio_sw_input.sv
// Bench for mio_sw_input: directed vector table, hand-written corner sequences, random run against a model.
module tb_mio_sw_input;

   localparam int NSW = 16;
   localparam int DEB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sw_i;
   logic        sel;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mio_sw_input #(
      .NSW             (NSW),
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (16)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .sw_i  (sw_i),
      .sel   (sel),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   // Reference: a level is accepted once the last DEB synchronised samples agree and differ from it.
   logic [15:0] m_dly [2];
   logic [15:0] m_hist [DEB];
   logic [15:0] m_state, m_event, m_mask;
   logic        m_en, m_irq;

   always @(posedge clk) begin : model
      logic [15:0] same, fire, clr;
      logic        irq_nx;
      if (rst) begin
         m_dly[0] = '0; m_dly[1] = '0;
         for (int i = 0; i < DEB; i++) m_hist[i] = '0;
         m_state = '0; m_event = '0; m_mask = '0; m_en = 1'b0; m_irq = 1'b0;
      end else begin
         for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = m_dly[1];
         same = '1;
         for (int i = 1; i < DEB; i++) same = same & ~(m_hist[i] ^ m_hist[0]);
         fire   = same & (m_hist[0] ^ m_state);
         irq_nx = m_en & (|(m_event & m_mask));
         clr    = (sel && we && addr == 2'd1) ? wdata[15:0] : 16'h0;
         m_event = (m_event & ~clr) | fire;
         m_state = m_state ^ fire;
         if (sel && we && addr == 2'd2) begin
            m_en   = wdata[0];
            m_mask = wdata[31:16];
         end
         m_dly[1] = m_dly[0];
         m_dly[0] = sw_i;
         m_irq    = irq_nx;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic check_regs(input string tag, input logic [15:0] e_raw, input logic [15:0] e_st,
                             input logic [15:0] e_ev, input logic [31:0] e_ctrl, input logic e_irq);
      logic [31:0] d;
      rd(2'd0, d); chk({tag, " STATE"}, d, {16'h0, e_st});
      rd(2'd1, d); chk({tag, " EVENT"}, d, {16'h0, e_ev});
      rd(2'd2, d); chk({tag, " CTRL"},  d, e_ctrl);
      rd(2'd3, d); chk({tag, " RAW"},   d, {16'h0, e_raw});
      chk({tag, " irq"}, {31'h0, irq}, {31'h0, e_irq});
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr1(input logic [1:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      tick(1);
      sel = 1'b0; we = 1'b0; wdata = '0;
   endtask

   typedef struct {
      logic [15:0] sw;
      logic        wr;
      logic [1:0]  a;
      logic [31:0] wd;
      int          n;
      logic [15:0] raw;
      logic [15:0] st;
      logic [15:0] ev;
      logic [31:0] ctrl;
      logic        irq;
   } vec_t;

   vec_t vt [20];

   initial begin : stim
      logic [31:0] d;
      vt[0]  = '{16'h0005, 1'b0, 2'd0, 32'h0,         1, 16'h0000, 16'h0000, 16'h0000, 32'h0,         1'b0};
      vt[1]  = '{16'h0005, 1'b0, 2'd0, 32'h0,         1, 16'h0005, 16'h0000, 16'h0000, 32'h0,         1'b0};
      vt[2]  = '{16'h0005, 1'b0, 2'd0, 32'h0,         3, 16'h0005, 16'h0000, 16'h0000, 32'h0,         1'b0};
      vt[3]  = '{16'h0005, 1'b0, 2'd0, 32'h0,         1, 16'h0005, 16'h0005, 16'h0005, 32'h0,         1'b0};
      vt[4]  = '{16'h0005, 1'b1, 2'd1, 32'h1,         1, 16'h0005, 16'h0005, 16'h0004, 32'h0,         1'b0};
      vt[5]  = '{16'h0005, 1'b1, 2'd2, 32'h0004_0001, 1, 16'h0005, 16'h0005, 16'h0004, 32'h0004_0001, 1'b0};
      vt[6]  = '{16'h0005, 1'b0, 2'd0, 32'h0,         1, 16'h0005, 16'h0005, 16'h0004, 32'h0004_0001, 1'b1};
      vt[7]  = '{16'h0005, 1'b1, 2'd1, 32'h4,         1, 16'h0005, 16'h0005, 16'h0000, 32'h0004_0001, 1'b1};
      vt[8]  = '{16'h0005, 1'b0, 2'd0, 32'h0,         1, 16'h0005, 16'h0005, 16'h0000, 32'h0004_0001, 1'b0};
      vt[9]  = '{16'h0001, 1'b1, 2'd2, 32'h0001_0001, 6, 16'h0001, 16'h0001, 16'h0004, 32'h0001_0001, 1'b0};
      vt[10] = '{16'h0001, 1'b0, 2'd0, 32'h0,         1, 16'h0001, 16'h0001, 16'h0004, 32'h0001_0001, 1'b0};
      vt[11] = '{16'h0009, 1'b0, 2'd0, 32'h0,         3, 16'h0009, 16'h0001, 16'h0004, 32'h0001_0001, 1'b0};
      vt[12] = '{16'h0001, 1'b0, 2'd0, 32'h0,         1, 16'h0009, 16'h0001, 16'h0004, 32'h0001_0001, 1'b0};
      vt[13] = '{16'h0001, 1'b0, 2'd0, 32'h0,         4, 16'h0001, 16'h0001, 16'h0004, 32'h0001_0001, 1'b0};
      vt[14] = '{16'h0009, 1'b0, 2'd0, 32'h0,         5, 16'h0009, 16'h0001, 16'h0004, 32'h0001_0001, 1'b0};
      vt[15] = '{16'h0009, 1'b0, 2'd0, 32'h0,         1, 16'h0009, 16'h0009, 16'h000C, 32'h0001_0001, 1'b0};
      vt[16] = '{16'h0009, 1'b1, 2'd0, 32'hFFFF_FFFF, 1, 16'h0009, 16'h0009, 16'h000C, 32'h0001_0001, 1'b0};
      vt[17] = '{16'h0009, 1'b1, 2'd3, 32'hFFFF_FFFF, 1, 16'h0009, 16'h0009, 16'h000C, 32'h0001_0001, 1'b0};
      vt[18] = '{16'h0009, 1'b1, 2'd2, 32'hFFFF_FFFF, 1, 16'h0009, 16'h0009, 16'h000C, 32'hFFFF_0001, 1'b0};
      vt[19] = '{16'h0009, 1'b0, 2'd0, 32'h0,         1, 16'h0009, 16'h0009, 16'h000C, 32'hFFFF_0001, 1'b1};

      rst = 1'b1; sw_i = '0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      tick(2);
      check_regs("reset", 16'h0, 16'h0, 16'h0, 32'h0, 1'b0);
      rst = 1'b0;
      tick(1);
      check_regs("idle", 16'h0, 16'h0, 16'h0, 32'h0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         sw_i = vt[i].sw;
         if (vt[i].wr) begin
            wr1(vt[i].a, vt[i].wd);
            tick(vt[i].n - 1);
         end else begin
            tick(vt[i].n);
         end
         check_regs($sformatf("vec%0d", i), vt[i].raw, vt[i].st, vt[i].ev, vt[i].ctrl, vt[i].irq);
      end

      // Set beats clear: W1C of bit0 lands on the edge that commits a new bit0 level.
      sw_i = 16'h0008;
      wr1(2'd1, 32'hFFFF_FFFF);
      tick(4);
      rd(2'd0, d); chk("collide pre STATE", d, 32'h0009);
      rd(2'd1, d); chk("collide pre EVENT", d, 32'h0000);
      wr1(2'd1, 32'h1);
      rd(2'd0, d); chk("collide STATE", d, 32'h0008);
      rd(2'd1, d); chk("collide EVENT", d, 32'h0001);
      wr1(2'd1, 32'h1);
      rd(2'd1, d); chk("collide clr EVENT", d, 32'h0000);

      // Switches high through reset are reported as events once debounced.
      sw_i = 16'hFFFF; rst = 1'b1;
      tick(2);
      check_regs("hold rst", 16'h0, 16'h0, 16'h0, 32'h0, 1'b0);
      rst = 1'b0;
      tick(5);
      check_regs("hold c5", 16'hFFFF, 16'h0, 16'h0, 32'h0, 1'b0);
      tick(1);
      check_regs("hold c6", 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'h0, 1'b0);

      // Reset mid-count must discard counter progress.
      sw_i = 16'h0000;
      tick(4);
      rd(2'd0, d); chk("midrst pre STATE", d, 32'hFFFF);
      rst = 1'b1;
      tick(1);
      check_regs("midrst", 16'h0, 16'h0, 16'h0, 32'h0, 1'b0);
      rst = 1'b0; sw_i = 16'h0003;
      tick(5);
      check_regs("restart c5", 16'h0003, 16'h0, 16'h0, 32'h0, 1'b0);
      tick(1);
      check_regs("restart c6", 16'h0003, 16'h0003, 16'h0003, 32'h0, 1'b0);

      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         check_regs("rnd", m_dly[1], m_state, m_event, {m_mask, 15'h0, m_en}, m_irq);
         sw_i  = sw_i ^ 16'($urandom & $urandom & $urandom);
         sel   = ($urandom_range(0, 3) != 0);
         we    = ($urandom_range(0, 2) == 0);
         addr  = 2'($urandom);
         wdata = $urandom;
         rst   = ($urandom_range(0, 199) == 0);
         tick(1);
      end
      check_regs("rnd end", m_dly[1], m_state, m_event, {m_mask, 15'h0, m_en}, m_irq);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
